wb_unit: RTL

WB_UNIT -- requirements
Module: wb_unit

---
 rtl/wb_unit_if.sv | 32 +++
 rtl/wb_unit.sv | 99 +++++++++
 2 files changed

// File: rtl/wb_unit_if.sv
// Writeback bus between the MEM stage / data memory and the writeback unit.
// The master side drives requests and memory responses; the slave side is the unit.
interface wb_unit_if #(
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd_src;
  logic             in_is_load;
  logic [31:0]      in_alu_result;
  logic [2:0]       in_funct3;
  logic [1:0]       in_addr_lo;
  logic             mem_rvalid;
  logic [31:0]      mem_rdata;
  logic             reg_we;
  logic [4:0]       rd_src;
  logic [31:0]      rd;
  logic             misalign;
  logic [CNT_W-1:0] retired;

  modport master (
    output in_valid, in_rd_src, in_is_load, in_alu_result, in_funct3, in_addr_lo,
           mem_rvalid, mem_rdata,
    input  in_ready, reg_we, rd_src, rd, misalign, retired
  );

  modport slave (
    input  in_valid, in_rd_src, in_is_load, in_alu_result, in_funct3, in_addr_lo,
           mem_rvalid, mem_rdata,
    output in_ready, reg_we, rd_src, rd, misalign, retired
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback unit: retires ALU results directly and waits for one load response,
// extracting and extending the addressed byte/half/word before the regfile write.
module wb_unit #(
  parameter int CNT_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  wb_unit_if.slave   bus
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t     state;
  logic [4:0] pend_rd;
  logic [2:0] pend_funct3;
  logic [1:0] pend_addr;

  function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] a);
    // NOTE: the default arm covers every unlisted funct3, so the result is always assigned.
    case (f3)
      F3_LB, F3_LBU: load_legal = 1'b1;
      F3_LH, F3_LHU: load_legal = ~a[0];
      F3_LW:         load_legal = (a == 2'b00);
      default:       load_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                               input logic [1:0]  a,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      F3_LB:   load_extract = {{24{b[7]}}, b};
      F3_LBU:  load_extract = {24'h0, b};
      F3_LH:   load_extract = {{16{h[15]}}, h};
      F3_LHU:  load_extract = {16'h0, h};
      default: load_extract = w;
    endcase
  endfunction

  assign bus.in_ready = (state == IDLE);

  // NOTE: all state here is sequential, so every assignment is non-blocking.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      pend_rd      <= '0;
      pend_funct3  <= '0;
      pend_addr    <= '0;
      bus.reg_we   <= 1'b0;
      bus.rd_src   <= '0;
      bus.rd       <= '0;
      bus.misalign <= 1'b0;
      bus.retired  <= '0;
    end else begin
      bus.reg_we   <= 1'b0;
      bus.misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            if (!bus.in_is_load) begin
              bus.reg_we  <= (bus.in_rd_src != 5'd0);
              bus.rd_src  <= bus.in_rd_src;
              bus.rd      <= bus.in_alu_result;
              bus.retired <= bus.retired + CNT_W'(1);
            end else if (load_legal(bus.in_funct3, bus.in_addr_lo)) begin
              state       <= WAIT_MEM;
              pend_rd     <= bus.in_rd_src;
              pend_funct3 <= bus.in_funct3;
              pend_addr   <= bus.in_addr_lo;
            end else begin
              bus.misalign <= 1'b1;
              bus.retired  <= bus.retired + CNT_W'(1);
            end
          end
        end
        WAIT_MEM: begin
          if (bus.mem_rvalid) begin
            state       <= IDLE;
            bus.reg_we  <= (pend_rd != 5'd0);
            bus.rd_src  <= pend_rd;
            bus.rd      <= load_extract(pend_funct3, pend_addr, bus.mem_rdata);
            bus.retired <= bus.retired + CNT_W'(1);
          end
        end
      endcase
    end
  end

endmodule
